md_unit: RTL and testbench

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_unit.sv | 194 +++++++++++++++++++
 tb/tb_md_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// md_unit: iterative RISC-V M-extension multiply/divide unit.
// Multiplication is shift-add on operand magnitudes. Division is radix-2 restoring
// division on operand magnitudes. The sign of the result is fixed in the FINISH state.
// Optional macro MDU_FAST_MUL_EN: func3[2]=0 ops use a single-cycle 33x33 signed
// multiplier and skip CALC. Division is unaffected.

module md_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  func3,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {StIdle, StCalc, StFinish} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  func_q, func_d;
    logic        neg_a_q, neg_a_d;
    logic        neg_b_q, neg_b_d;
    logic [31:0] mb_q, mb_d;       // multiplicand (mul) or divisor (div) magnitude
    logic [31:0] hi_q, hi_d;       // product high half / partial remainder
    logic [31:0] lo_q, lo_d;       // multiplier -> product low half / dividend -> quotient
    logic        done_q, done_d;
    logic [31:0] result_q, result_d;

    logic        accept;
    logic        fast_mul;
    logic        sgn_a_in, sgn_b_in;
    logic        neg_a_in, neg_b_in;
    logic [31:0] mag_a_in, mag_b_in;
    logic [32:0] mul_sum;
    logic [32:0] div_rem;
    logic        div_ge;
    logic [63:0] prod_abs, prod_fix;
    logic [31:0] quo_fix, rem_fix, fin_res;

    assign accept = (state_q == StIdle) && start && !flush;

`ifdef MDU_FAST_MUL_EN
    logic [63:0] fast_prod;
    // Sign-extended 33-bit operands; the low 64 bits equal the signed product.
    assign fast_prod = {{31{neg_a_in}}, neg_a_in, op_a} * {{31{neg_b_in}}, neg_b_in, op_b};
    assign fast_mul  = !func3[2];
`else
    assign fast_mul  = 1'b0;
`endif

    // Operand decode: the signedness of each input and its magnitude
    always_comb begin
        if (func3[2]) begin
            sgn_a_in = !func3[0];
            sgn_b_in = !func3[0];
        end else begin
            sgn_a_in = (func3[1:0] != 2'b11);
            sgn_b_in = !func3[1];
        end
        neg_a_in = sgn_a_in && op_a[31];
        neg_b_in = sgn_b_in && op_b[31];
        mag_a_in = neg_a_in ? (~op_a + 32'd1) : op_a;
        mag_b_in = neg_b_in ? (~op_b + 32'd1) : op_b;
    end

    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mb_q} : 33'd0);
    assign div_rem = {hi_q, lo_q[31]};
    assign div_ge  = (div_rem >= {1'b0, mb_q});

    // Result sign fix and selection, used in FINISH
    always_comb begin
        prod_abs = {hi_q, lo_q};
        prod_fix = (neg_a_q ^ neg_b_q) ? (~prod_abs + 64'd1) : prod_abs;
        quo_fix  = (neg_a_q ^ neg_b_q) ? (~lo_q + 32'd1) : lo_q;
        rem_fix  = neg_a_q ? (~hi_q + 32'd1) : hi_q;
        case (func_q)
            3'b000:                 fin_res = prod_fix[31:0];
            3'b001, 3'b010, 3'b011: fin_res = prod_fix[63:32];
            3'b100, 3'b101:         fin_res = (mb_q == 32'd0) ? 32'hFFFF_FFFF : quo_fix;
            default:                fin_res = rem_fix;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // FSM next state; flush wins over everything else
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (accept) state_d = fast_mul ? StFinish : StCalc;
            StCalc:   if (cnt_q == 5'd31) state_d = StFinish;
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (flush) state_d = StIdle;
    end

    // FSM outputs
    always_comb begin
        busy   = (state_q != StIdle);
        done   = done_q;
        result = result_q;
    end

    // Datapath next state: capture on accept, iterate in CALC, publish in FINISH
    always_comb begin
        cnt_d    = cnt_q;
        func_d   = func_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        mb_d     = mb_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        result_d = result_q;
        if (!flush) begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        cnt_d   = 5'd0;
                        func_d  = func3;
                        neg_a_d = neg_a_in;
                        neg_b_d = neg_b_in;
                        hi_d    = 32'd0;
                        if (func3[2]) begin
                            mb_d = mag_b_in;
                            lo_d = mag_a_in;
                        end else begin
                            mb_d = mag_a_in;
                            lo_d = mag_b_in;
                        end
`ifdef MDU_FAST_MUL_EN
                        if (!func3[2]) begin
                            // Product is already signed; suppress the FINISH sign fix.
                            {hi_d, lo_d} = fast_prod;
                            neg_a_d      = 1'b0;
                            neg_b_d      = 1'b0;
                        end
`endif
                    end
                end
                StCalc: begin
                    cnt_d = cnt_q + 5'd1;
                    if (!func_q[2]) begin
                        {hi_d, lo_d} = {mul_sum, lo_q[31:1]};
                    end else begin
                        // Remainder after a successful subtract is below the divisor, so 32 bits suffice.
                        hi_d = div_ge ? (div_rem[31:0] - mb_q) : div_rem[31:0];
                        lo_d = {lo_q[30:0], div_ge};
                    end
                end
                StFinish: begin
                    result_d = fin_res;
                    done_d   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= 5'd0;
            func_q   <= 3'd0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            mb_q     <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
            result_q <= 32'd0;
        end else begin
            cnt_q    <= cnt_d;
            func_q   <= func_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            mb_q     <= mb_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: self-checking bench for md_unit.
// The vector table, a randomized run checked against an arithmetic reference model,
// and hand sequences for flush, reset and held-start.

module tb_md_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  func3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] last_res;

`ifdef MDU_FAST_MUL_EN
    localparam bit Fast = 1'b1;
`else
    localparam bit Fast = 1'b0;
`endif

    always #5 clk = ~clk;

    md_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .func3  (func3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic [2:0] f);
        int lat = 34;
        if (Fast && (f[2] == 1'b0)) lat = 2;
        return lat;
    endfunction

    // Reference model: plain 64-bit arithmetic with the RISC-V corner cases
    function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] up;
        logic [31:0] r;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin up = sa * sb; r = up[31:0];  end
            3'd1: begin up = sa * sb; r = up[63:32]; end
            3'd2: begin up = sa * ub; r = up[63:32]; end
            3'd3: begin up = ua * ub; r = up[63:32]; end
            3'd4: begin
                if (b == 32'd0)  r = 32'hFFFF_FFFF;
                else if (ovf)    r = 32'h8000_0000;
                else begin up = sa / sb; r = up[31:0]; end
            end
            3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0)  r = a;
                else if (ovf)    r = 32'd0;
                else begin up = sa % sb; r = up[31:0]; end
            end
            default: r = (b == 32'd0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Raise start for one cycle, then scramble inputs to prove they were captured.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        func3 = f;
        op_a  = a;
        op_b  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        func3 = 3'($urandom);
        op_a  = $urandom;
        op_b  = $urandom;
    endtask

    // Called in cycle 1; returns at the negedge of the done cycle.
    task automatic wait_done(input string name, input logic [31:0] exp_res, input int lat);
        int cyc     = 0;
        bit seen    = 1'b0;
        bit busy_ok = 1'b1;
        while (!seen && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1'b1;
            else if (!busy) busy_ok = 1'b0;
        end
        chk({name, " latency"}, 32'(cyc), 32'(lat));
        chk({name, " result"}, result, exp_res);
        chk({name, " busy_at_done"}, {31'd0, busy}, 32'd0);
        chk({name, " busy_during"}, {31'd0, busy_ok}, 32'd1);
        last_res = exp_res;
    endtask

    initial begin
        int          n_done;
        int          first_done;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "MUL 7*-3"};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, "MULHU max*max"};
        vecs[2]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHSU -1*max"};
        vecs[3]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, "MULH min*min"};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, "DIV -7/2"};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, "REM -7/2"};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        "DIVU 100/7"};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         "REMU 100/7"};
        vecs[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, "DIVU 5/0"};
        vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         "REM 5/0"};
        vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "DIV ovf"};
        vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         "REM ovf"};
        vecs[12] = '{3'd4, 32'hFFFF_FFF8,  32'd0,         32'hFFFF_FFFF, "DIV -8/0"};
        vecs[13] = '{3'd6, 32'hFFFF_FFF8,  32'd0,         32'hFFFF_FFF8, "REM -8/0"};
        vecs[14] = '{3'd7, 32'd5,          32'd0,         32'd5,         "REMU 5/0"};
        vecs[15] = '{3'd0, 32'h0001_0003,  32'h0002_0005, 32'h000B_000F, "MUL wrap"};

        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        func3 = 3'd0;
        op_a  = 32'd0;
        op_b  = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset result", result, 32'd0);

        // First start comes in the very first cycle after reset release; the rest run back-to-back.
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            issue(vecs[i].f, vecs[i].a, vecs[i].b);
            wait_done(vecs[i].name, vecs[i].exp, exp_lat(vecs[i].f));
        end

        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom);
            a = rnd_op();
            b = rnd_op();
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(f, a, b);
            wait_done($sformatf("rand%0d f=%0d a=%h b=%h", i, f, a, b), ref_md(f, a, b),
                      exp_lat(f));
        end

        // Flush in cycle 10, restart in cycle 11
        @(posedge clk);
        #1;
        issue(3'd4, 32'd1000, 32'd3);
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush busy", {31'd0, busy}, 32'd0);
        chk("flush done", {31'd0, done}, 32'd0);
        chk("flush result", result, last_res);
        issue(3'd5, 32'd1000, 32'd3);
        wait_done("after flush DIVU", 32'd333, 34);

        // Flush during FINISH suppresses done
        @(posedge clk);
        #1;
        issue(3'd7, 32'd1000, 32'd7);
        repeat (32) begin @(posedge clk); #1; end
        chk("finish busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("finish flush done", {31'd0, done}, 32'd0);
        chk("finish flush busy", {31'd0, busy}, 32'd0);
        chk("finish flush result", result, last_res);

        // Asynchronous reset in cycle 20 of an op
        @(posedge clk);
        #1;
        issue(3'd4, 32'd12345, 32'd7);
        repeat (19) begin @(posedge clk); #1; end
        #2;
        rst_n = 1'b0;
        #1;
        chk("midop reset busy", {31'd0, busy}, 32'd0);
        chk("midop reset done", {31'd0, done}, 32'd0);
        chk("midop reset result", result, 32'd0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        last_res = 32'd0;
        n_done   = 0;
        repeat (50) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("no done after reset", 32'(n_done), 32'd0);

        // Start held through CALC/FINISH must give exactly one done
        @(posedge clk);
        #1;
        start = 1'b1;
        func3 = 3'd5;
        op_a  = 32'd77;
        op_b  = 32'd5;
        repeat (33) begin @(posedge clk); #1; end
        start      = 1'b0;
        n_done     = 0;
        first_done = -1;
        for (int c = 33; c < 83; c++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (first_done < 0) first_done = c;
            end
        end
        chk("held start done count", 32'(n_done), 32'd1);
        chk("held start done cycle", 32'(first_done), 32'd34);
        chk("held start result", result, 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
